// File: rtl/hacd_pkg.sv
// Shared types and constants for the HACD compression/decompression path.
// Holds the decompressor FSM encoding and page geometry.
package hacd_pkg;

  localparam int HAWK_LINES_PER_PAGE = 64;
  localparam int HAWK_HDR_BITMAP_W   = 64;

  typedef enum logic [2:0] {
    IDLE,
    LDPTR,
    HDR,
    EXPAND,
    DONE
  } decomp_state_t;

  typedef logic [5:0] line_idx_t;

endpackage

// File: rtl/hawk_decompressor.sv
// Zero-line page decompressor: reads a presence-bitmap header and the packed
// non-zero lines from the read FIFO, writes all 64 expanded lines in order.
module hawk_decompressor
  import hacd_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int STRB_W = 64,
  parameter int LINES  = HAWK_LINES_PER_PAGE,
  parameter int PTR_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              decomp_start,
  output logic              decomp_done,
  output logic              decomp_err,
  output logic [6:0]        decomp_size,
  output logic [PTR_W-1:0]  rdfifo_rdptr,
  output logic              ld_rdfifo_rdptr,
  input  logic              rdfifo_empty,
  output logic              rd_req,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        rd_rresp,
  input  logic              rd_valid,
  input  logic              wrfifo_full,
  output logic              wr_req,
  output logic [STRB_W-1:0] wr_strb,
  output logic [DATA_W-1:0] wr_data
);

  decomp_state_t                  state_q, state_d;
  logic [HAWK_HDR_BITMAP_W-1:0]   bitmap_q;
  line_idx_t                      line_idx_q;
  logic [6:0]                     beats_q;
  logic                           err_q;

  logic head_ok, cur_bit, last_line;
  logic bitmap_ld, cnt_clr, line_inc, beat_inc, err_set, err_clr;

  assign head_ok      = !rdfifo_empty && rd_valid;
  assign cur_bit      = bitmap_q[line_idx_q];
  assign last_line    = (line_idx_q == line_idx_t'(LINES - 1));
  assign rdfifo_rdptr = '0;
  assign wr_strb      = '1;
  assign decomp_err   = err_q;
  assign decomp_size  = beats_q;

  always_comb begin
    state_d         = state_q;
    decomp_done     = 1'b0;
    ld_rdfifo_rdptr = 1'b0;
    rd_req          = 1'b0;
    wr_req          = 1'b0;
    wr_data         = '0;
    bitmap_ld       = 1'b0;
    cnt_clr         = 1'b0;
    line_inc        = 1'b0;
    beat_inc        = 1'b0;
    err_set         = 1'b0;
    err_clr         = 1'b0;
    case (state_q)
      IDLE: if (decomp_start) state_d = LDPTR;
      LDPTR: begin
        ld_rdfifo_rdptr = 1'b1;
        cnt_clr         = 1'b1;
        state_d         = HDR;
      end
      HDR: begin
        rd_req = head_ok;
        if (head_ok) begin
          if (rd_rresp == 2'b00) begin
            bitmap_ld = 1'b1;
            state_d   = EXPAND;
          end else begin
            err_set = 1'b1;
            state_d = DONE;
          end
        end
      end
      EXPAND: begin
        if (!cur_bit) begin
          wr_req = !wrfifo_full;
        end else if (head_ok) begin
          // A bad beat is dropped even if the write side is full: nothing is written for it.
          if (rd_rresp != 2'b00) begin
            rd_req  = 1'b1;
            err_set = 1'b1;
            state_d = DONE;
          end else if (!wrfifo_full) begin
            rd_req   = 1'b1;
            wr_req   = 1'b1;
            wr_data  = rd_data;
            beat_inc = 1'b1;
          end
        end
        if (wr_req) begin
          line_inc = 1'b1;
          if (last_line) state_d = DONE;
        end
      end
      DONE: begin
        decomp_done = 1'b1;
        if (!decomp_start) begin
          err_clr = 1'b1;
          cnt_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bitmap_q   <= '0;
      line_idx_q <= '0;
      beats_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bitmap_ld) bitmap_q <= rd_data[HAWK_HDR_BITMAP_W-1:0];
      if (cnt_clr) begin
        line_idx_q <= '0;
        beats_q    <= '0;
      end else begin
        if (line_inc) line_idx_q <= line_idx_q + line_idx_t'(1);
        if (beat_inc) beats_q    <= beats_q + 7'd1;
      end
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hawk_decompressor.sv
// Directed bench for hawk_decompressor: behavioural FIFOs around the DUT,
// one task per scenario with inline expected-value checks.
module tb_hawk_decompressor;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          decomp_start;
  logic          decomp_done, decomp_err;
  logic [6:0]    decomp_size;
  logic [5:0]    rdfifo_rdptr;
  logic          ld_rdfifo_rdptr;
  logic          rdfifo_empty, rd_req, rd_valid;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_rresp;
  logic          wrfifo_full, wr_req;
  logic [63:0]   wr_strb;
  logic [DW-1:0] wr_data;

  hawk_decompressor dut (
    .clk_i(clk), .rst_i(rst), .decomp_start(decomp_start),
    .decomp_done(decomp_done), .decomp_err(decomp_err), .decomp_size(decomp_size),
    .rdfifo_rdptr(rdfifo_rdptr), .ld_rdfifo_rdptr(ld_rdfifo_rdptr),
    .rdfifo_empty(rdfifo_empty), .rd_req(rd_req), .rd_data(rd_data),
    .rd_rresp(rd_rresp), .rd_valid(rd_valid), .wrfifo_full(wrfifo_full),
    .wr_req(wr_req), .wr_strb(wr_strb), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } beat_t;

  beat_t         rq[$];
  logic [DW-1:0] wq[$];
  bit            force_empty, pop_pend;
  int            cyc, pops, wrs, nowr_pops, ld_cnt, viol;
  int            total, bad;

  function automatic logic [DW-1:0] beat_val(input int k);
    return {16{32'hA500_0000 | 32'(k)}};
  endfunction

  task automatic refresh();
    rd_valid     = (rq.size() != 0);
    rdfifo_empty = !rd_valid || force_empty;
    rd_data      = rd_valid ? rq[0].d : '0;
    rd_rresp     = rd_valid ? rq[0].r : 2'b00;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [1:0] r);
    beat_t b;
    b.d = d;
    b.r = r;
    rq.push_back(b);
    refresh();
  endtask

  // Header upper bits carry junk that the DUT must ignore.
  task automatic load_hdr(input logic [63:0] bm);
    push_beat({{(DW-64){1'b1}}, bm}, 2'b00);
  endtask

  task automatic clear_stats();
    pops = 0; wrs = 0; nowr_pops = 0; ld_cnt = 0; viol = 0;
    wq.delete();
  endtask

  // Monitor: samples between edges; FIFO pops are applied just after the edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (ld_rdfifo_rdptr) ld_cnt++;
      if (wr_req) begin
        if (wrfifo_full) viol++;
        wq.push_back(wr_data);
        wrs++;
      end
      if (rd_req && rdfifo_empty) viol++;
      if (rd_req && !rdfifo_empty) begin
        pop_pend = 1'b1;
        pops++;
        if (!wr_req) nowr_pops++;
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pop_pend) begin
      void'(rq.pop_front());
      pop_pend = 1'b0;
      refresh();
    end
  end

  // Latency counts cycles from the edge that accepts decomp_start.
  task automatic wait_done(input int t0, output int lat);
    int k = 0;
    while (!decomp_done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    lat = decomp_done ? (cyc - t0 - 1) : -1;
    if (!decomp_done) begin
      total++; bad++;
      $display("FAIL wait_done timeout");
    end
  endtask

  task automatic wait_wrs(input int n);
    int k = 0;
    while (wrs < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (wrs < n) begin
      total++; bad++;
      $display("FAIL wait_wrs timeout got=%0d exp=%0d", wrs, n);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({decomp_done, decomp_err, decomp_size, ld_rdfifo_rdptr, rd_req, wr_req} !== 12'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0",
               {decomp_done, decomp_err, decomp_size, ld_rdfifo_rdptr, rd_req, wr_req});
    end
    total++;
    if (wr_strb !== {64{1'b1}} || rdfifo_rdptr !== 6'd0) begin
      bad++;
      $display("FAIL reset_consts strb=%h ptr=%0d exp=all-ones/0", wr_strb, rdfifo_rdptr);
    end
  endtask

  task automatic test_all_zero();
    int t0, lat, nz;
    clear_stats();
    load_hdr(64'h0);
    decomp_start = 1'b1;
    t0 = cyc;
    wait_done(t0, lat);
    nz = 0;
    foreach (wq[i]) if (wq[i] !== '0) nz++;
    total++; if (lat !== 66) begin bad++; $display("FAIL zero_latency got=%0d exp=66", lat); end
    total++; if (pops !== 1) begin bad++; $display("FAIL zero_pops got=%0d exp=1", pops); end
    total++; if (wrs !== 64) begin bad++; $display("FAIL zero_writes got=%0d exp=64", wrs); end
    total++; if (nz !== 0) begin bad++; $display("FAIL zero_data nonzero=%0d exp=0", nz); end
    total++; if (decomp_size !== 7'd0 || decomp_err !== 1'b0) begin
      bad++; $display("FAIL zero_size_err size=%0d err=%b exp=0/0", decomp_size, decomp_err);
    end
    decomp_start = 1'b0;
    @(negedge clk);
    total++; if (decomp_done !== 1'b0) begin bad++; $display("FAIL zero_done_drop got=%b exp=0", decomp_done); end
  endtask

  task automatic test_all_ones();
    int t0, lat, mis;
    clear_stats();
    load_hdr(64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 64; k++) push_beat(beat_val(k), 2'b00);
    decomp_start = 1'b1;
    t0 = cyc;
    wait_done(t0, lat);
    mis = 0;
    for (int k = 0; k < 64; k++) if (k >= wq.size() || wq[k] !== beat_val(k)) mis++;
    total++; if (lat !== 66) begin bad++; $display("FAIL ones_latency got=%0d exp=66", lat); end
    total++; if (pops !== 65 || nowr_pops !== 1) begin
      bad++; $display("FAIL ones_pops got=%0d/%0d exp=65/1", pops, nowr_pops);
    end
    total++; if (wrs !== 64 || mis !== 0) begin
      bad++; $display("FAIL ones_data writes=%0d badlines=%0d exp=64/0", wrs, mis);
    end
    total++; if (decomp_size !== 7'd64) begin bad++; $display("FAIL ones_size got=%0d exp=64", decomp_size); end
    // start still high: stay in DONE, no restart
    repeat (3) @(negedge clk);
    total++; if (decomp_done !== 1'b1 || ld_cnt !== 1) begin
      bad++; $display("FAIL ones_hold done=%b ld=%0d exp=1/1", decomp_done, ld_cnt);
    end
    decomp_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_end_lines();
    int t0, lat, nz, hi;
    logic [DW-1:0] a, b;
    a = beat_val(16'hAAAA);
    b = beat_val(16'hBBBB);
    clear_stats();
    load_hdr(64'h8000_0000_0000_0001);
    push_beat(a, 2'b00);
    push_beat(b, 2'b00);
    decomp_start = 1'b1;
    t0 = cyc;
    wait_wrs(10);
    decomp_start = 1'b0;
    wait_done(t0, lat);
    nz = 0;
    for (int k = 1; k < 63 && k < wq.size(); k++) if (wq[k] !== '0) nz++;
    hi = wq.size() - 1;
    total++; if (wq.size() !== 64 || wq[0] !== a) begin
      bad++; $display("FAIL ends_line0 n=%0d got=%h exp=%h", wq.size(), wq[0], a);
    end
    total++; if (wq[hi] !== b) begin bad++; $display("FAIL ends_line63 got=%h exp=%h", wq[hi], b); end
    total++; if (nz !== 0) begin bad++; $display("FAIL ends_middle nonzero=%0d exp=0", nz); end
    total++; if (decomp_size !== 7'd2 || lat !== 66) begin
      bad++; $display("FAIL ends_size_lat size=%0d lat=%0d exp=2/66", decomp_size, lat);
    end
    @(negedge clk);
    total++; if (decomp_done !== 1'b0) begin bad++; $display("FAIL ends_idle got=%b exp=0", decomp_done); end
  endtask

  task automatic test_stalls();
    int t0, lat, nz;
    logic [DW-1:0] x, y;
    x = beat_val(16'h1111);
    y = beat_val(16'h2222);
    clear_stats();
    load_hdr(64'h5);
    push_beat(x, 2'b00);
    push_beat(y, 2'b00);
    decomp_start = 1'b1;
    t0 = cyc;
    wait_wrs(1);
    wrfifo_full = 1'b1;
    repeat (3) @(negedge clk);
    wrfifo_full = 1'b0;
    wait_wrs(2);
    force_empty = 1'b1; refresh();
    repeat (2) @(negedge clk);
    force_empty = 1'b0; refresh();
    wait_done(t0, lat);
    nz = 0;
    foreach (wq[i]) if (i != 0 && i != 2 && wq[i] !== '0) nz++;
    total++; if (lat !== 71) begin bad++; $display("FAIL stall_latency got=%0d exp=71", lat); end
    total++; if (viol !== 0) begin bad++; $display("FAIL stall_protocol violations=%0d exp=0", viol); end
    total++; if (pops !== 3 || nowr_pops !== 1) begin
      bad++; $display("FAIL stall_pops got=%0d/%0d exp=3/1", pops, nowr_pops);
    end
    total++; if (wq.size() !== 64 || wq[0] !== x || wq[2] !== y || nz !== 0) begin
      bad++; $display("FAIL stall_order n=%0d nz=%0d exp=64/0", wq.size(), nz);
    end
    total++; if (decomp_size !== 7'd2) begin bad++; $display("FAIL stall_size got=%0d exp=2", decomp_size); end
    decomp_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_resp();
    int t0, lat;
    clear_stats();
    load_hdr(64'h7);
    push_beat(beat_val(1), 2'b00);
    push_beat(beat_val(2), 2'b10);
    push_beat(beat_val(3), 2'b00);
    decomp_start = 1'b1;
    t0 = cyc;
    wait_done(t0, lat);
    total++; if (decomp_err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b exp=1", decomp_err); end
    total++; if (wrs !== 1 || wq.size() < 1 || wq[0] !== beat_val(1)) begin
      bad++; $display("FAIL err_writes got=%0d exp=1", wrs);
    end
    total++; if (pops !== 3 || decomp_size !== 7'd1) begin
      bad++; $display("FAIL err_pops_size pops=%0d size=%0d exp=3/1", pops, decomp_size);
    end
    decomp_start = 1'b0;
    @(negedge clk);
    total++; if (decomp_err !== 1'b0 || decomp_done !== 1'b0) begin
      bad++; $display("FAIL err_clear err=%b done=%b exp=0/0", decomp_err, decomp_done);
    end
    rq.delete(); refresh();
  endtask

  task automatic test_reset_mid();
    int t0, lat;
    clear_stats();
    load_hdr(64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 64; k++) push_beat(beat_val(k), 2'b00);
    decomp_start = 1'b1;
    wait_wrs(20);
    rst = 1'b1;
    #1;
    total++; if ({wr_req, rd_req, ld_rdfifo_rdptr, decomp_done, decomp_size} !== 11'h0) begin
      bad++; $display("FAIL rstmid_outputs got=%b exp=0",
                      {wr_req, rd_req, ld_rdfifo_rdptr, decomp_done, decomp_size});
    end
    decomp_start = 1'b0;
    @(negedge clk);
    rq.delete(); pop_pend = 1'b0; refresh();
    rst = 1'b0;
    @(negedge clk);
    clear_stats();
    load_hdr(64'h0);
    decomp_start = 1'b1;
    t0 = cyc;
    wait_done(t0, lat);
    total++; if (ld_cnt !== 1 || wrs !== 64 || lat !== 66) begin
      bad++; $display("FAIL rstmid_restart ld=%0d writes=%0d lat=%0d exp=1/64/66", ld_cnt, wrs, lat);
    end
    decomp_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    decomp_start = 1'b0;
    wrfifo_full = 1'b0;
    force_empty = 1'b0;
    pop_pend = 1'b0;
    cyc = 0; total = 0; bad = 0;
    clear_stats();
    refresh();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_all_zero();
    test_all_ones();
    test_end_lines();
    test_stalls();
    test_bad_resp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
